// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU issue-stage sequencer.
// The request entry is packed as {opc, a, b, seld} with seld in the low bits.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int OPC_W    = 8;
    localparam int OPD_W    = 8;
    localparam int SELD_W   = 2;
    localparam int SELD_LSB = 0;
    localparam int B_LSB    = SELD_LSB + SELD_W;
    localparam int A_LSB    = B_LSB + OPD_W;
    localparam int OPC_LSB  = A_LSB + OPD_W;
    localparam int ENTRY_W  = OPC_LSB + OPC_W;

    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;
    localparam int WCNT_W      = 8;

    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [OPD_W-1:0]  a;
        logic [OPD_W-1:0]  b;
        logic [SELD_W-1:0] seld;
    } req_t;

    function automatic logic [ENTRY_W-1:0] pack_req(input req_t r);
        logic [ENTRY_W-1:0] e;
        e = {ENTRY_W{1'b0}};
        e[OPC_LSB  +: OPC_W]  = r.opc;
        e[A_LSB    +: OPD_W]  = r.a;
        e[B_LSB    +: OPD_W]  = r.b;
        e[SELD_LSB +: SELD_W] = r.seld;
        return e;
    endfunction

    function automatic req_t unpack_req(input logic [ENTRY_W-1:0] e);
        req_t r;
        r.opc  = e[OPC_LSB  +: OPC_W];
        r.a    = e[A_LSB    +: OPD_W];
        r.b    = e[B_LSB    +: OPD_W];
        r.seld = e[SELD_LSB +: SELD_W];
        return r;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-side and result signals of the sequencer bundled as one interface.
// slave is the sequencer's view; master is the surrounding environment's view.
interface alu_op_sequencer_if;
    import alu_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  in_opc;
    logic [OPD_W-1:0]  in_a;
    logic [OPD_W-1:0]  in_b;
    logic [SELD_W-1:0] in_seld;
    logic              alu_enable;
    logic [OPC_W-1:0]  alu_opc;
    logic [OPD_W-1:0]  alu_a;
    logic [OPD_W-1:0]  alu_b;
    logic [SELD_W-1:0] alu_seld;
    logic [OPD_W-1:0]  alu_z;
    logic              alu_done;
    logic              res_valid;
    logic              res_ready;
    logic [OPD_W-1:0]  res_z;
    logic [OPC_W-1:0]  res_opc;
    logic              res_timeout;
    logic              busy;

    modport slave (
        input  in_valid, in_opc, in_a, in_b, in_seld, alu_z, alu_done, res_ready,
        output in_ready, alu_enable, alu_opc, alu_a, alu_b, alu_seld,
               res_valid, res_z, res_opc, res_timeout, busy
    );

    modport master (
        output in_valid, in_opc, in_a, in_b, in_seld, alu_z, alu_done, res_ready,
        input  in_ready, alu_enable, alu_opc, alu_a, alu_b, alu_seld,
               res_valid, res_z, res_opc, res_timeout, busy
    );
endinterface

// File: rtl/op_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two so pointers wrap naturally.
module op_fifo #(
    parameter  int WIDTH = 26,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == {CNT_W{1'b0}});
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// One-op-in-flight issue stage in front of a free-running ALU: queue, issue,
// wait for done (with timeout), then hold the result on a valid/ready handshake.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic               clock,
    input logic               reset,
    alu_op_sequencer_if.slave bus
);

    localparam int FCNT_W = $clog2(DEPTH + 1);

    state_e               state_q, state_d;
    logic [WCNT_W-1:0]    wait_cnt_q, wait_cnt_d, wait_inc;
    req_t                 alu_req_q, alu_req_d;
    logic                 alu_enable_q, alu_enable_d;
    logic                 res_valid_q, res_valid_d;
    logic [OPD_W-1:0]     res_z_q, res_z_d;
    logic [OPC_W-1:0]     res_opc_q, res_opc_d;
    logic                 res_timeout_q, res_timeout_d;

    req_t                 in_req;
    logic                 in_ready_s;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]   fifo_wdata, fifo_rdata;
    logic [FCNT_W-1:0]    fifo_count;

    assign in_req     = '{opc: bus.in_opc, a: bus.in_a, b: bus.in_b, seld: bus.in_seld};
    assign fifo_wdata = pack_req(in_req);
    // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
    assign in_ready_s = !reset && (fifo_count < FCNT_W'(DEPTH));
    assign fifo_push  = bus.in_valid && in_ready_s && !fifo_full;

    op_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // FSM next-state, issue strobe, wait counter and result capture.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        alu_req_d     = alu_req_q;
        alu_enable_d  = 1'b0;
        res_valid_d   = res_valid_q;
        res_z_d       = res_z_q;
        res_opc_d     = res_opc_q;
        res_timeout_d = res_timeout_q;
        fifo_pop      = 1'b0;
        wait_inc      = wait_cnt_q + WCNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    alu_req_d    = unpack_req(fifo_rdata);
                    alu_enable_d = 1'b1;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = {WCNT_W{1'b0}};
                if (bus.alu_done) begin
                    res_valid_d   = 1'b1;
                    res_z_d       = bus.alu_z;
                    res_opc_d     = alu_req_q.opc;
                    res_timeout_d = 1'b0;
                    state_d       = ST_HOLD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_inc;
                // A done arriving in the final wait cycle beats the timeout.
                if (bus.alu_done) begin
                    res_valid_d   = 1'b1;
                    res_z_d       = bus.alu_z;
                    res_opc_d     = alu_req_q.opc;
                    res_timeout_d = 1'b0;
                    state_d       = ST_HOLD;
                end else if (wait_inc == WCNT_W'(TIMEOUT)) begin
                    res_valid_d   = 1'b1;
                    res_z_d       = {OPD_W{1'b0}};
                    res_opc_d     = alu_req_q.opc;
                    res_timeout_d = 1'b1;
                    state_d       = ST_HOLD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered FSM state and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= {WCNT_W{1'b0}};
            alu_req_q     <= '{opc: 8'h00, a: 8'h00, b: 8'h00, seld: 2'b00};
            alu_enable_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_z_q       <= {OPD_W{1'b0}};
            res_opc_q     <= {OPC_W{1'b0}};
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            alu_req_q     <= alu_req_d;
            alu_enable_q  <= alu_enable_d;
            res_valid_q   <= res_valid_d;
            res_z_q       <= res_z_d;
            res_opc_q     <= res_opc_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.alu_enable  = alu_enable_q;
    assign bus.alu_opc     = alu_req_q.opc;
    assign bus.alu_a       = alu_req_q.a;
    assign bus.alu_b       = alu_req_q.b;
    assign bus.alu_seld    = alu_req_q.seld;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_z       = res_z_q;
    assign bus.res_opc     = res_opc_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a latency/result vector table plus
// hand-written full-FIFO, backpressure and mid-operation reset sequences.
module tb_alu_op_sequencer;

    localparam int T_OUT = 16;
    localparam int NEVER = 255;
    localparam int NVEC  = 6;

    typedef struct {
        logic [7:0] opc;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] seld;
        int         lat;
        logic [7:0] z;
        logic [7:0] exp_z;
        logic       exp_to;
        int         exp_lat;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [NVEC];

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(
        .DEPTH   (4),
        .TIMEOUT (T_OUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [7:0] opc, input logic [7:0] a,
                            input logic [7:0] b, input logic [1:0] seld);
        int w;
        bus.in_valid = 1'b1;
        bus.in_opc   = opc;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_seld  = seld;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        check("push_accept", 32'(w < 50), 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_enable();
        int w;
        w = 0;
        while (!bus.alu_enable && w < 20) begin
            @(negedge clock);
            w++;
        end
        check("issue_seen", 32'(bus.alu_enable), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_enable"},  32'(bus.alu_enable),  32'd0);
        check({tag, "_alu_opc"},     32'(bus.alu_opc),     32'd0);
        check({tag, "_alu_a"},       32'(bus.alu_a),       32'd0);
        check({tag, "_alu_b"},       32'(bus.alu_b),       32'd0);
        check({tag, "_alu_seld"},    32'(bus.alu_seld),    32'd0);
        check({tag, "_res_valid"},   32'(bus.res_valid),   32'd0);
        check({tag, "_res_z"},       32'(bus.res_z),       32'd0);
        check({tag, "_res_opc"},     32'(bus.res_opc),     32'd0);
        check({tag, "_res_timeout"}, 32'(bus.res_timeout), 32'd0);
        check({tag, "_busy"},        32'(bus.busy),        32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         en_cnt;
        int         got;
        logic [7:0] seen_opc [$];

        vecs[0] = '{opc: 8'h01, a: 8'h09, b: 8'h04, seld: 2'd0, lat: 2,     z: 8'h05, exp_z: 8'h05, exp_to: 1'b0, exp_lat: 3};
        vecs[1] = '{opc: 8'h02, a: 8'h10, b: 8'h20, seld: 2'd1, lat: 0,     z: 8'h30, exp_z: 8'h30, exp_to: 1'b0, exp_lat: 1};
        vecs[2] = '{opc: 8'h03, a: 8'hFF, b: 8'h01, seld: 2'd2, lat: NEVER, z: 8'h77, exp_z: 8'h00, exp_to: 1'b1, exp_lat: 17};
        vecs[3] = '{opc: 8'h04, a: 8'hA0, b: 8'h5A, seld: 2'd3, lat: 16,    z: 8'hA5, exp_z: 8'hA5, exp_to: 1'b0, exp_lat: 17};
        vecs[4] = '{opc: 8'h05, a: 8'h55, b: 8'hAA, seld: 2'd0, lat: 15,    z: 8'h5A, exp_z: 8'h5A, exp_to: 1'b0, exp_lat: 16};
        vecs[5] = '{opc: 8'h80, a: 8'h7F, b: 8'h80, seld: 2'd1, lat: 1,     z: 8'hFF, exp_z: 8'hFF, exp_to: 1'b0, exp_lat: 2};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_opc    = 8'h00;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.in_seld   = 2'd0;
        bus.alu_z     = 8'h00;
        bus.alu_done  = 1'b0;
        bus.res_ready = 1'b0;

        repeat (2) @(negedge clock);
        #1;
        check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
        check_all_zero("reset");
        @(negedge clock);

        // Table: one op each, done after lat cycles (0 = in ISSUE, NEVER = timeout).
        for (int v = 0; v < NVEC; v++) begin
            push_req(vecs[v].opc, vecs[v].a, vecs[v].b, vecs[v].seld);
            wait_enable();
            check("alu_opc",  32'(bus.alu_opc),  32'(vecs[v].opc));
            check("alu_a",    32'(bus.alu_a),    32'(vecs[v].a));
            check("alu_b",    32'(bus.alu_b),    32'(vecs[v].b));
            check("alu_seld", 32'(bus.alu_seld), 32'(vecs[v].seld));
            k      = 0;
            en_cnt = 0;
            got    = 0;
            while (got == 0 && k < 40) begin
                if (k > 0 && bus.res_valid) begin
                    got = 1;
                end else begin
                    if (bus.alu_enable) en_cnt++;
                    bus.alu_done = (k == vecs[v].lat);
                    bus.alu_z    = (k == vecs[v].lat) ? vecs[v].z : 8'hEE;
                    @(negedge clock);
                    k++;
                end
            end
            bus.alu_done = 1'b0;
            check("res_valid_seen", 32'(got),             32'd1);
            check("res_latency",    32'(k),               32'(vecs[v].exp_lat));
            check("enable_pulses",  32'(en_cnt),          32'd1);
            check("res_z",          32'(bus.res_z),       32'(vecs[v].exp_z));
            check("res_opc",        32'(bus.res_opc),     32'(vecs[v].opc));
            check("res_timeout",    32'(bus.res_timeout), 32'(vecs[v].exp_to));
            check("busy_in_hold",   32'(bus.busy),        32'd1);
            bus.res_ready = 1'b1;
            @(negedge clock);
            bus.res_ready = 1'b0;
            check("res_valid_drop", 32'(bus.res_valid), 32'd0);
        end

        // Full FIFO: a blocker op parks in HOLD, then five back-to-back pushes.
        bus.alu_done = 1'b1;
        bus.alu_z    = 8'h11;
        push_req(8'h40, 8'h00, 8'h00, 2'd0);
        k = 0;
        while (!bus.res_valid && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("blocker_hold", 32'(bus.res_opc), 32'h40);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_opc   = 8'h50 + 8'(i);
            check("full_in_ready_free", 32'(bus.in_ready), 32'd1);
            @(negedge clock);
        end
        bus.in_opc = 8'h54;
        check("full_in_ready_drop", 32'(bus.in_ready), 32'd0);
        repeat (3) begin
            @(negedge clock);
            check("full_in_ready_held", 32'(bus.in_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(negedge clock);
        bus.res_ready = 1'b0;
        check("full_before_pop", 32'(bus.in_ready), 32'd0);
        @(negedge clock);
        check("full_slot_after_pop", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        check("full_again", 32'(bus.in_ready), 32'd0);
        bus.res_ready = 1'b1;
        k = 0;
        while (seen_opc.size() < 5 && k < 80) begin
            if (bus.res_valid) begin
                seen_opc.push_back(bus.res_opc);
                check("full_res_z", 32'(bus.res_z), 32'h11);
            end
            @(negedge clock);
            k++;
        end
        bus.res_ready = 1'b0;
        bus.alu_done  = 1'b0;
        check("full_res_count", 32'(seen_opc.size()), 32'd5);
        for (int i = 0; i < seen_opc.size(); i++) begin
            check("full_order", 32'(seen_opc[i]), 32'h50 + 32'(i));
        end
        @(negedge clock);
        check("full_busy_idle", 32'(bus.busy), 32'd0);

        // Backpressure: result must stay frozen while alu_z/alu_done wiggle.
        bus.in_valid = 1'b1;
        bus.in_opc = 8'h61; bus.in_a = 8'h01; bus.in_b = 8'h02; bus.in_seld = 2'd0;
        @(negedge clock);
        bus.in_opc = 8'h62; bus.in_a = 8'h03; bus.in_b = 8'h04; bus.in_seld = 2'd1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        check("bp_issue_a", 32'(bus.alu_enable), 32'd1);
        check("bp_opc_a",   32'(bus.alu_opc),    32'h61);
        bus.alu_done = 1'b1;
        bus.alu_z    = 8'h3E;
        @(negedge clock);
        bus.alu_done = 1'b0;
        check("bp_res_valid", 32'(bus.res_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.alu_z    = 8'(i * 37 + 5);
            bus.alu_done = (i % 2 == 0);
            @(negedge clock);
            check("bp_res_z_stable", 32'(bus.res_z),      32'h3E);
            check("bp_valid_held",   32'(bus.res_valid),  32'd1);
            check("bp_no_enable",    32'(bus.alu_enable), 32'd0);
            check("bp_alu_opc_held", 32'(bus.alu_opc),    32'h61);
        end
        bus.alu_done  = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clock);
        bus.res_ready = 1'b0;
        check("bp_released", 32'(bus.res_valid), 32'd0);
        @(negedge clock);
        check("bp_issue_b", 32'(bus.alu_enable), 32'd1);
        check("bp_opc_b",   32'(bus.alu_opc),    32'h62);
        check("bp_a_b",     32'(bus.alu_a),      32'h03);
        bus.alu_done = 1'b1;
        bus.alu_z    = 8'hC4;
        @(negedge clock);
        bus.alu_done = 1'b0;
        check("bp_res_z_b",   32'(bus.res_z),   32'hC4);
        check("bp_res_opc_b", 32'(bus.res_opc), 32'h62);
        bus.res_ready = 1'b1;
        @(negedge clock);
        bus.res_ready = 1'b0;

        // Reset while one op waits and three more are queued.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_opc   = 8'h70 + 8'(i);
            bus.in_a     = 8'(i + 1);
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_pre_busy", 32'(bus.busy),    32'd1);
        check("rst_pre_opc",  32'(bus.alu_opc), 32'h70);
        reset = 1'b1;
        #1;
        check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.alu_done = 1'b1;
        bus.alu_z    = 8'hAB;
        repeat (4) begin
            @(negedge clock);
            check("midrst_no_result", 32'(bus.res_valid),  32'd0);
            check("midrst_no_issue",  32'(bus.alu_enable), 32'd0);
        end
        bus.alu_done = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Issue stage that sits directly upstream of `alu_8bit`. It buffers operation requests (opcode, operands, select) in a small FIFO, issues them one at a time on the ALU's `enable` / `opc` / `a` / `b` / `seld` inputs, and waits for `done` with a timeout. It then captures `z` and presents the result downstream on a valid/ready handshake. It converts the ALU's free-running interface into a flow-controlled, one-op-in-flight pipeline stage.

## Interface
Parameters:
- `DEPTH`, 4: request FIFO entries; power of two, ≥ 2.
- `TIMEOUT`, 16: maximum WAIT cycles before the op is abandoned; range 1..255.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_opc`  in  8  ALU opcode.
- `in_a`, `in_b`  in  8 each  operands.
- `in_seld`  in  2  ALU `seld` value.
- `alu_enable`  out  1  one-cycle issue strobe to ALU `enable`.
- `alu_opc`  out  8  to ALU `opc`.
- `alu_a`, `alu_b`  out  8 each  to ALU `a`, `b`.
- `alu_seld`  out  2  to ALU `seld`.
- `alu_z`  in  8  ALU result.
- `alu_done`  in  1  ALU completion.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts.
- `res_z`  out  8  captured result.
- `res_opc`  out  8  opcode of the result.
- `res_timeout`  out  1  result abandoned; `res_z` = 0.
- `busy`  out  1  FIFO non-empty or state ≠ IDLE.

## Operation
- FIFO entry is 26 bits: {opc, a, b, seld}.
  - Push when `in_valid && in_ready`; `in_ready` = count < DEPTH.
  - Push while full is refused, even in a cycle where a pop occurs.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if the FIFO is non-empty, pop, register the entry onto the `alu_*` outputs, and go to ISSUE. Otherwise stay.
- ISSUE: `alu_enable` = 1 for exactly this cycle; the wait counter loads 0.
  - If `alu_done` = 1 in this cycle, capture `alu_z` and go to HOLD.
  - Otherwise go to WAIT.
- WAIT: the counter increments each cycle.
  - On `alu_done` = 1, capture `alu_z` into `res_z` with `res_timeout` = 0, then go to HOLD.
  - If the counter reaches TIMEOUT with `alu_done` = 0, set `res_z` = 8'h00 and `res_timeout` = 1, then go to HOLD.
  - If `alu_done` and the timeout coincide, done wins.
- HOLD: `res_valid` = 1.
  - `res_z`, `res_opc` and `res_timeout` stay stable until `res_ready` = 1; then go to IDLE.
  - `alu_done` is ignored in HOLD.
- `alu_opc`, `alu_a`, `alu_b` and `alu_seld` hold their value from pop until the next pop. The ALU is combinational on these inputs, so they must not glitch.
- Reset, including mid-operation: FIFO emptied, state IDLE, counter 0. Every output register goes to 0: `alu_*`, `res_*`, `alu_enable`, `busy`. `in_ready` = 0 while `reset` = 1. An in-flight op is dropped with no result.

## Timing
- Push at edge N into an empty FIFO while IDLE gives:
  - pop at edge N+1;
  - ISSUE (`alu_enable` high) during cycle N+1..N+2;
  - with `alu_done` in ISSUE, `res_valid` from edge N+2.
- Minimum op period is 3 cycles (IDLE, ISSUE, HOLD), given `res_ready` held high.
- Timeout: `res_valid` rises TIMEOUT+1 cycles after `alu_enable`.
- `in_ready` reflects the registered count; a pop frees a slot from the next cycle.
- All outputs are registered except `in_ready` and `busy`, which are decoded from registered state.

## Structure
- Package `alu_seq_pkg` holds:
  - the state enumeration (IDLE/ISSUE/WAIT/HOLD, 2 bits);
  - the request field widths and packed-entry layout (opc, a, b, seld offsets);
  - defaults for DEPTH and TIMEOUT.
- Sub-module `op_fifo`: synchronous FIFO, parameterized width/depth, with `clock` and `reset` (sync, active-high), push/pop, full/empty/count.
  - Pointers wrap modulo DEPTH.
  - Count is DEPTH+1-valued.
- The top level holds the FSM, wait counter, and result registers.

## Test plan
- Single op: push {opc=8'h01, a=8'h09, b=8'h04, seld=0}; ALU model asserts `done` with z=8'h05 two cycles after enable. Expect `alu_enable` for exactly 1 cycle, then `res_valid` with `res_z`=8'h05, `res_opc`=8'h01, `res_timeout`=0.
- Full FIFO: push 5 requests back-to-back with `res_ready`=0 and done immediate.
  - Expect 4 accepted (`in_ready` drops after 4) and the 5th refused until a pop.
  - Order is preserved in `res_opc`.
- Timeout: TIMEOUT=16 with `alu_done` held 0. Expect `res_valid` 17 cycles after `alu_enable`, `res_z`=8'h00, `res_timeout`=1, and the next op issued after acceptance.
- Coincident done/timeout: `alu_done` pulses in the 16th WAIT cycle with z=8'hA5. Expect `res_z`=8'hA5, `res_timeout`=0.
- Backpressure: `res_ready`=0 for 10 cycles in HOLD while `alu_z` changes. Expect `res_z` stable, no new `alu_enable`, and a second queued op issued only after the handshake.
- Reset mid-WAIT: assert `reset` for 1 cycle with 3 entries queued.
  - Expect all outputs 0 and `busy`=0.
  - A later `alu_done` produces no `res_valid`; `in_ready`=1 after reset is released.
